// File: rtl/selftrigger_peak_detector.sv
// selftrigger_peak_detector: threshold/hysteresis self-trigger with peak, position and width tracking
module selftrigger_peak_detector #(
  parameter int W = 16,
  parameter int MAX_WIDTH = 255,
  parameter int CNT_W = 8,
  parameter int HO_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] threshold,
  input  logic [7:0]          hysteresis,
  input  logic [HO_W-1:0]     holdoff,
  output logic                trigger,
  output logic signed [W-1:0] peak,
  output logic [CNT_W-1:0]    peak_pos,
  output logic [CNT_W-1:0]    width,
  output logic                truncated,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, ACTIVE, REPORT, HOLDOFF, REARM} state_t;
  state_t state;
  logic signed [W:0] xs, ts, fl;
  logic signed [W-1:0] cur_max;
  logic [CNT_W-1:0] cur_pos, cnt;
  logic [HO_W-1:0] ho_cnt;
  logic rise, fall, up, last;
  assign xs = {x[W-1], x};
  assign ts = {threshold[W-1], threshold};
  assign fl = ts - (W+1)'(hysteresis);
  assign rise = xs > ts;
  assign fall = xs <= fl;
  assign up = x > cur_max;
  // a non-falling sample is counted first, so the MAX_WIDTH-th one closes the event
  assign last = cnt == CNT_W'(MAX_WIDTH - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      trigger <= 1'b0;
      peak <= '0;
      peak_pos <= '0;
      width <= '0;
      truncated <= 1'b0;
      cur_max <= '0;
      cur_pos <= '0;
      cnt <= '0;
      ho_cnt <= '0;
    end else begin
      trigger <= 1'b0;
      case (state)
        IDLE: if (enable && rise) begin
          state <= ACTIVE;
          cur_max <= x;
          cur_pos <= '0;
          cnt <= CNT_W'(1);
        end
        ACTIVE: if (enable) begin
          if (fall) begin
            state <= REPORT;
            trigger <= 1'b1;
            peak <= cur_max;
            peak_pos <= cur_pos;
            width <= cnt;
            truncated <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (up) begin
              cur_max <= x;
              cur_pos <= cnt;
            end
            if (last) begin
              state <= REPORT;
              trigger <= 1'b1;
              peak <= up ? x : cur_max;
              peak_pos <= up ? cnt : cur_pos;
              width <= cnt + 1'b1;
              truncated <= 1'b1;
            end
          end
        end
        REPORT: begin
          ho_cnt <= holdoff;
          state <= holdoff == '0 ? REARM : HOLDOFF;
        end
        HOLDOFF: if (enable) begin
          ho_cnt <= ho_cnt - 1'b1;
          if (ho_cnt == HO_W'(1)) state <= REARM;
        end
        REARM: if (enable && fall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
